vga_sync_ctrl: RTL and testbench

VGA_SYNC_CTRL -- requirements
Module: vga_sync_ctrl

---
 rtl/vga_pkg.sv | 55 +++++
 rtl/vga_axis_counter.sv | 76 +++++++
 rtl/vga_sync_ctrl.sv | 164 ++++++++++++++++
 tb/tb_vga_sync_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_pkg
//  Purpose  : Shared VGA timing defaults, line/frame totals, phase encoding
//             and colour reset values for vga_sync_ctrl and vga_axis_counter.
//  Contents : C_CLK_DIV             - system clocks per pixel
//             C_H_* / C_V_*         - phase lengths (BP, ACT, FP, SYNC order)
//             C_H_TOTAL / C_V_TOTAL - pixels per line / lines per frame
//             phase_t               - axis phase state encoding
//  Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

    // Pixel clock divider: 100 MHz system clock -> 25 MHz pixel rate.
    localparam int C_CLK_DIV = 4;

    // Horizontal phase lengths in pixels.
    localparam int C_H_BP   = 48;
    localparam int C_H_ACT  = 640;
    localparam int C_H_FP   = 16;
    localparam int C_H_SYNC = 96;

    // Vertical phase lengths in lines.
    localparam int C_V_BP   = 30;
    localparam int C_V_ACT  = 480;
    localparam int C_V_FP   = 13;
    localparam int C_V_SYNC = 2;

    // Width of the Posx/Posy counters.
    localparam int C_POS_W = 10;

    // Sum of the four phase lengths of one axis.
    function automatic int phase_total(input int bp, input int act,
                                       input int fp, input int sync);
        return bp + act + fp + sync;
    endfunction

    localparam int C_H_TOTAL = phase_total(C_H_BP, C_H_ACT, C_H_FP, C_H_SYNC);
    localparam int C_V_TOTAL = phase_total(C_V_BP, C_V_ACT, C_V_FP, C_V_SYNC);

    // Axis phase encoding, in the order the phases occur along the axis.
    typedef enum logic [1:0] {
        PH_BP   = 2'd0,
        PH_ACT  = 2'd1,
        PH_FP   = 2'd2,
        PH_SYNC = 2'd3
    } phase_t;

    // Colour register reset values.
    localparam logic [7:0] C_FG_RESET = 8'hFF;
    localparam logic [7:0] C_BG_RESET = 8'h00;

endpackage
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_axis_counter
//  Purpose  : One display axis: position counter 0..TOTAL-1 plus an explicit
//             BP -> ACT -> FP -> SYNC phase state machine.  Used once for the
//             horizontal axis (enabled per pixel) and once for the vertical
//             axis (enabled per line wrap).
//  Ports    : Clk   in   system clock
//             reset in   synchronous active-high reset
//             en    in   advance strobe (one Clk wide)
//             pos   out  current position, 0..TOTAL-1
//             state out  current phase (vga_pkg::phase_t encoding)
//             wrap  out  en while pos is TOTAL-1 (position returns to 0)
//  Revision : 1.0  initial release
// ============================================================================
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int BP    = C_H_BP,
    parameter int ACT   = C_H_ACT,
    parameter int FP    = C_H_FP,
    parameter int SYNC  = C_H_SYNC,
    parameter int WIDTH = C_POS_W
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             en,
    output logic [WIDTH-1:0] pos,
    output logic [1:0]       state,
    output logic             wrap
);

    localparam int c_total = phase_total(BP, ACT, FP, SYNC);

    // Last position of each phase; the state machine leaves a phase when the
    // counter is enabled while sitting on that phase's last position.
    localparam logic [WIDTH-1:0] c_bp_last  = WIDTH'(BP - 1);
    localparam logic [WIDTH-1:0] c_act_last = WIDTH'(BP + ACT - 1);
    localparam logic [WIDTH-1:0] c_fp_last  = WIDTH'(BP + ACT + FP - 1);
    localparam logic [WIDTH-1:0] c_last     = WIDTH'(c_total - 1);

    // Every phase must be at least one position long and the whole axis must
    // fit in the counter.
    if (BP < 1 || ACT < 1 || FP < 1 || SYNC < 1) begin : g_phase_len_chk
        $error("vga_axis_counter: every phase length must be >= 1");
    end
    if (c_total > (1 << WIDTH)) begin : g_width_chk
        $error("vga_axis_counter: axis total does not fit in WIDTH bits");
    end

    logic [WIDTH-1:0] r_pos;
    phase_t           r_state;

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_pos   <= '0;
            r_state <= PH_BP;
        end else if (en) begin
            r_pos <= (r_pos == c_last) ? '0 : r_pos + WIDTH'(1);
            case (r_state)
                PH_BP:   if (r_pos == c_bp_last)  r_state <= PH_ACT;
                PH_ACT:  if (r_pos == c_act_last) r_state <= PH_FP;
                PH_FP:   if (r_pos == c_fp_last)  r_state <= PH_SYNC;
                PH_SYNC: if (r_pos == c_last)     r_state <= PH_BP;
                default:                          r_state <= PH_BP;
            endcase
        end
    end

    assign pos   = r_pos;
    assign state = r_state;
    assign wrap  = en && (r_pos == c_last);

endmodule
`default_nettype wire

// File: rtl/vga_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : vga_sync_ctrl
//  Purpose  : VGA timing generator.  Divides Clk down to the pixel rate,
//             tracks the raster position, produces active-low hsync/vsync
//             and a registered RGB332 pixel colour chosen from the glyph /
//             background colours latched once per frame.
//  Ports    : Clk         in   system clock
//             reset       in   synchronous active-high reset
//             blank       in   blanking flag (valid one Clk after Posx/Posy)
//             letra       in   glyph-pixel flag (same timing as blank)
//             fg_color    in   glyph colour RGB332, latched at frame start
//             bg_color    in   background colour RGB332, latched at frame start
//             Posx        out  horizontal pixel count, 0..H total-1
//             Posy        out  vertical line count, 0..V total-1
//             hsync       out  horizontal sync, active-low
//             vsync       out  vertical sync, active-low
//             pix_tick    out  last Clk of each pixel period
//             frame_start out  pix_tick on which the raster returns to 0,0
//             rgb         out  registered RGB332 pixel colour
//  Revision : 1.0  initial release
// ============================================================================
module vga_sync_ctrl
    import vga_pkg::*;
#(
    parameter int CLK_DIV = C_CLK_DIV,
    parameter int H_BP    = C_H_BP,
    parameter int H_ACT   = C_H_ACT,
    parameter int H_FP    = C_H_FP,
    parameter int H_SYNC  = C_H_SYNC,
    parameter int V_BP    = C_V_BP,
    parameter int V_ACT   = C_V_ACT,
    parameter int V_FP    = C_V_FP,
    parameter int V_SYNC  = C_V_SYNC
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       blank,
    input  logic       letra,
    input  logic [7:0] fg_color,
    input  logic [7:0] bg_color,
    output logic [9:0] Posx,
    output logic [9:0] Posy,
    output logic       hsync,
    output logic       vsync,
    output logic       pix_tick,
    output logic       frame_start,
    output logic [7:0] rgb
);

    // A divider of 1 would leave no Clk between a position change and the
    // pix_tick that samples blank/letra for that position.
    if (CLK_DIV < 2) begin : g_clk_div_chk
        $error("vga_sync_ctrl: CLK_DIV must be >= 2");
    end

    localparam int                 c_div_w    = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);
    localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);

    // ------------------------------------------------------------------
    // Pixel-rate divider
    // ------------------------------------------------------------------
    logic [c_div_w-1:0] r_div_cnt;
    logic               w_pix_tick;

    assign w_pix_tick = (r_div_cnt == c_div_last);

    // ------------------------------------------------------------------
    // Horizontal and vertical axes
    // ------------------------------------------------------------------
    logic [9:0] w_h_pos;
    logic [9:0] w_v_pos;
    logic [1:0] w_h_state;
    logic [1:0] w_v_state;
    logic       w_h_wrap;
    logic       w_v_wrap;

    vga_axis_counter #(
        .BP    (H_BP),
        .ACT   (H_ACT),
        .FP    (H_FP),
        .SYNC  (H_SYNC),
        .WIDTH (10)
    ) u_h_axis (
        .Clk   (Clk),
        .reset (reset),
        .en    (w_pix_tick),
        .pos   (w_h_pos),
        .state (w_h_state),
        .wrap  (w_h_wrap)
    );

    // The vertical axis advances once per completed line; its wrap therefore
    // coincides with the last pixel of the frame.
    vga_axis_counter #(
        .BP    (V_BP),
        .ACT   (V_ACT),
        .FP    (V_FP),
        .SYNC  (V_SYNC),
        .WIDTH (10)
    ) u_v_axis (
        .Clk   (Clk),
        .reset (reset),
        .en    (w_h_wrap),
        .pos   (w_v_pos),
        .state (w_v_state),
        .wrap  (w_v_wrap)
    );

    // ------------------------------------------------------------------
    // Registered pixel outputs and per-frame colour registers
    // ------------------------------------------------------------------
    logic       r_hsync;
    logic       r_vsync;
    logic [7:0] r_rgb;
    logic [7:0] r_fg;
    logic [7:0] r_bg;
    logic       w_visible;

    assign w_visible = (w_h_state == PH_ACT) && (w_v_state == PH_ACT);

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_div_cnt <= '0;
            r_hsync   <= 1'b1;
            r_vsync   <= 1'b1;
            r_rgb     <= 8'h00;
            r_fg      <= C_FG_RESET;
            r_bg      <= C_BG_RESET;
        end else begin
            r_div_cnt <= w_pix_tick ? '0 : r_div_cnt + c_div_w'(1);

            // Outputs describe the pixel being left, so they trail Posx/Posy
            // by one pixel period and stay aligned with each other.
            if (w_pix_tick) begin
                r_hsync <= (w_h_state != PH_SYNC);
                r_vsync <= (w_v_state != PH_SYNC);
                if (blank || !w_visible) begin
                    r_rgb <= 8'h00;
                end else begin
                    r_rgb <= letra ? r_fg : r_bg;
                end
            end

            // Colours only change between frames so a frame is never drawn
            // with a mix of old and new colours.
            if (w_v_wrap) begin
                r_fg <= fg_color;
                r_bg <= bg_color;
            end
        end
    end

    assign Posx        = w_h_pos;
    assign Posy        = w_v_pos;
    assign pix_tick    = w_pix_tick;
    assign frame_start = w_v_wrap;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign rgb         = r_rgb;

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_vga_sync_ctrl
//  Purpose  : Self-checking bench for vga_sync_ctrl.  A reduced-raster
//             instance is compared every Clk against a reference model that
//             derives the raster position from elapsed clocks; a
//             default-parameter instance has its first line timing measured.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_sync_ctrl;

    // Reduced raster for the cycle-by-cycle model comparison.
    localparam int D  = 4;
    localparam int HB = 3;
    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HT = HB + HA + HF + HS;
    localparam int VB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VT = VB + VA + VF + VS;
    localparam int FT = HT * VT;
    localparam int MAXPIX = 4096;
    localparam int MAXFR  = 64;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       blank = 1'b0;
    logic       letra = 1'b0;
    logic [7:0] fg_color = 8'h00;
    logic [7:0] bg_color = 8'h00;

    logic [9:0] posx_s, posy_s, posx_d, posy_d;
    logic       hsync_s, vsync_s, tick_s, fs_s;
    logic       hsync_d, vsync_d, tick_d, fs_d;
    logic [7:0] rgb_s, rgb_d;

    always #5 Clk = ~Clk;

    vga_sync_ctrl #(
        .CLK_DIV (D),
        .H_BP    (HB), .H_ACT (HA), .H_FP (HF), .H_SYNC (HS),
        .V_BP    (VB), .V_ACT (VA), .V_FP (VF), .V_SYNC (VS)
    ) u_dut_small (
        .Clk         (Clk),
        .reset       (reset),
        .blank       (blank),
        .letra       (letra),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .Posx        (posx_s),
        .Posy        (posy_s),
        .hsync       (hsync_s),
        .vsync       (vsync_s),
        .pix_tick    (tick_s),
        .frame_start (fs_s),
        .rgb         (rgb_s)
    );

    vga_sync_ctrl u_dut_def (
        .Clk         (Clk),
        .reset       (reset),
        .blank       (blank),
        .letra       (letra),
        .fg_color    (fg_color),
        .bg_color    (bg_color),
        .Posx        (posx_d),
        .Posy        (posy_d),
        .hsync       (hsync_d),
        .vsync       (vsync_d),
        .pix_tick    (tick_d),
        .frame_start (fs_d),
        .rgb         (rgb_d)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (time %0t)", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model state
    //   n        : Clk edges since the last reset edge
    //   blank_h  : blank/letra seen when each pixel was left
    //   fgf/bgf  : colours in force for each frame since reset
    // ------------------------------------------------------------------
    int         n = 0;
    bit         blank_h [MAXPIX];
    bit         letra_h [MAXPIX];
    logic [7:0] fgf     [MAXFR];
    logic [7:0] bgf     [MAXFR];

    // Default-instance line measurements.
    bit def_track = 0;
    int low_cnt   = 0;
    int first_low = -1;
    int wrap_at   = -1;
    int fs_d_cnt  = 0;

    task automatic check_all();
        int         p, q, qx, qy;
        logic       exp_hs, exp_vs;
        logic [7:0] exp_rgb;
        bit         act;
        p = n / D;
        check_val("posx", 32'(posx_s), p % HT);
        check_val("posy", 32'(posy_s), (p / HT) % VT);
        check_val("pix_tick", 32'(tick_s), 32'(n % D == D - 1));
        check_val("frame_start", 32'(fs_s), 32'((n % D == D - 1) && (p % FT == FT - 1)));
        if (p == 0) begin
            exp_hs  = 1'b1;
            exp_vs  = 1'b1;
            exp_rgb = 8'h00;
        end else begin
            q      = p - 1;
            qx     = q % HT;
            qy     = (q / HT) % VT;
            exp_hs = !(qx >= HB + HA + HF);
            exp_vs = !(qy >= VB + VA + VF);
            act    = (qx >= HB) && (qx < HB + HA) && (qy >= VB) && (qy < VB + VA);
            if (!act || blank_h[q]) exp_rgb = 8'h00;
            else                    exp_rgb = letra_h[q] ? fgf[q / FT] : bgf[q / FT];
        end
        check_val("hsync", 32'(hsync_s), 32'(exp_hs));
        check_val("vsync", 32'(vsync_s), 32'(exp_vs));
        check_val("rgb", 32'(rgb_s), 32'(exp_rgb));

        if (def_track) begin
            if (!hsync_d) begin
                low_cnt++;
                if (first_low < 0) first_low = n;
            end
            if (posx_d == 10'd0 && posy_d == 10'd1 && wrap_at < 0) wrap_at = n;
            if (fs_d) fs_d_cnt++;
        end
    endtask

    // One Clk: update the model at the rising edge, compare at the falling edge.
    task automatic step();
        int p;
        @(posedge Clk);
        if (reset) begin
            n      = 0;
            fgf[0] = 8'hFF;
            bgf[0] = 8'h00;
        end else begin
            if (n % D == D - 1) begin
                p = n / D;
                blank_h[p % MAXPIX] = blank;
                letra_h[p % MAXPIX] = letra;
                if (p % FT == FT - 1) begin
                    fgf[(p / FT + 1) % MAXFR] = fg_color;
                    bgf[(p / FT + 1) % MAXFR] = bg_color;
                end
            end
            n++;
        end
        @(negedge Clk);
        check_all();
    endtask

    // New blank/letra at the start of each pixel; rare colour changes.
    task automatic drive_random();
        if (n % D == 0) begin
            blank = ($urandom_range(0, 3) == 0);
            letra = $urandom_range(0, 1) == 1;
        end
        if ($urandom_range(0, 149) == 0) fg_color = 8'($urandom);
        if ($urandom_range(0, 149) == 0) bg_color = 8'($urandom);
    endtask

    initial begin
        // Reset held for 3 Clk.
        reset = 1'b1;
        repeat (3) step();
        check_val("def_reset_posx", 32'(posx_d), 0);
        check_val("def_reset_hsync", 32'(hsync_d), 1);
        check_val("def_reset_rgb", 32'(rgb_d), 0);
        reset = 1'b0;

        // Free run with random pixel data; measure the default line.
        def_track = 1;
        for (int i = 0; i < 3400; i++) begin
            drive_random();
            step();
        end
        def_track = 0;
        check_val("def_hsync_low_clks", 32'(low_cnt), 384);
        check_val("def_hsync_first_low", 32'(first_low), 2820);
        check_val("def_line_period", 32'(wrap_at), 3200);
        check_val("def_no_frame_start", 32'(fs_d_cnt), 0);

        // Restart, then glyph colour E0 on every pixel.
        reset = 1'b1;
        repeat (2) step();
        reset    = 1'b0;
        blank    = 1'b0;
        letra    = 1'b1;
        fg_color = 8'hE0;
        bg_color = 8'h00;
        repeat (2 * FT * D + 20) step();

        // Background pixels, bg changed mid-frame.
        letra = 1'b0;
        repeat ((FT / 2) * D) step();
        bg_color = 8'h03;
        repeat (2 * FT * D) step();

        // Random data with resets landing mid-line / mid-frame.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0, lim = $urandom_range(150, 1200); i < lim; i++) begin
                drive_random();
                step();
            end
            reset = 1'b1;
            repeat ($urandom_range(1, 2)) step();
            reset = 1'b0;
        end
        for (int i = 0; i < 700; i++) begin
            drive_random();
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
